dot_product_mac: RTL

//  Downstream consumer of the dual-memory reader stage. Takes paired element streams (A, B) and multiplies each pair.

---
 rtl/dotp_pkg.sv | 22 ++
 rtl/dotp_result_fifo.sv | 57 +++++
 rtl/dot_product_mac.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/dotp_pkg.sv
// Shared types and helpers for the dot-product MAC: FSM state, result record, width helper.
package dotp_pkg;

    localparam int DOTP_IDX_W = 3;
    localparam int DOTP_ACC_W = 18;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } dotp_state_t;

    typedef struct packed {
        logic [DOTP_IDX_W-1:0] index;
        logic [DOTP_ACC_W-1:0] data;
    } dotp_result_t;

    // Width that holds vw full-scale unsigned dw x dw products without overflow.
    function automatic int dotp_acc_width(input int dw, input int vw);
        return 2 * dw + $clog2(vw);
    endfunction

endpackage

// File: rtl/dotp_result_fifo.sv
// Two-entry synchronous result FIFO; a push on full is accepted only if a pop frees the slot that cycle.
module dotp_result_fifo
    import dotp_pkg::*;
#(
    parameter type T = dotp_result_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output T     head,
    output logic full,
    output logic empty,
    output logic dropped
);

    T           mem_r [2];
    logic       wr_ptr_r;
    logic       rd_ptr_r;
    logic [1:0] count_r;
    logic       wr_en_s;
    logic       rd_en_s;

    assign full    = (count_r == 2'd2);
    assign empty   = (count_r == 2'd0);
    assign rd_en_s = pop && !empty;
    assign wr_en_s = push && (!full || pop);
    assign dropped = push && full && !pop;
    assign head    = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (rd_en_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/dot_product_mac.sv
// Pipelined unsigned dot-product MAC with a 2-entry result FIFO and valid/ready output.
// Define DOTP_SATURATE_EN to clamp the accumulator at its maximum instead of wrapping.
module dot_product_mac
    import dotp_pkg::*;
#(
    parameter  int DATA_WIDTH   = 8,
    parameter  int VECTOR_WIDTH = 4,
    parameter  int NUM_VECTORS  = 8,
    parameter  int ACC_WIDTH    = dotp_acc_width(DATA_WIDTH, VECTOR_WIDTH),
    localparam int IDX_W        = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic                  in_last,
    output logic [ACC_WIDTH-1:0]  result_data,
    output logic [IDX_W-1:0]      result_index,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic                  busy,
    output logic                  overflow_err,
    output logic                  frame_err
);

    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int ECNT_W = $clog2(VECTOR_WIDTH);
    localparam int SUM_W  = ((ACC_WIDTH > PROD_W) ? ACC_WIDTH : PROD_W) + 1;
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {ACC_WIDTH{1'b1}};

    typedef struct packed {
        logic [IDX_W-1:0]     index;
        logic [ACC_WIDTH-1:0] data;
    } res_t;

    dotp_state_t         state_r;
    logic [PROD_W-1:0]   prod_r;
    logic                s1_valid_r;
    logic                s1_last_r;
    logic [ACC_WIDTH-1:0] acc_r;
    logic [ECNT_W-1:0]   ecnt_r;
    logic [IDX_W-1:0]    vidx_r;
    logic                push_r;
    res_t                push_res_r;
    logic                overflow_err_r;
    logic                frame_err_r;

    logic [SUM_W-1:0]     sum_wide_s;
    logic [ACC_WIDTH-1:0] sum_s;
    logic                 end_vec_s;
    res_t                 head_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic                 fifo_drop_s;

    assign end_vec_s = (ecnt_r == ECNT_W'(VECTOR_WIDTH - 1));

    // Next accumulator value, wrapping or clamping at the accumulator width.
    always_comb begin
        sum_wide_s = SUM_W'(acc_r) + SUM_W'(prod_r);
`ifdef DOTP_SATURATE_EN
        if (sum_wide_s > SUM_W'(ACC_MAX)) begin
            sum_s = ACC_MAX;
        end else begin
            sum_s = ACC_WIDTH'(sum_wide_s);
        end
`else
        sum_s = ACC_WIDTH'(sum_wide_s);
`endif
    end

    // Multiply stage, accumulate stage, element/vector counters, sticky flags and FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            prod_r         <= '0;
            s1_valid_r     <= 1'b0;
            s1_last_r      <= 1'b0;
            acc_r          <= '0;
            ecnt_r         <= '0;
            vidx_r         <= '0;
            push_r         <= 1'b0;
            push_res_r     <= '0;
            overflow_err_r <= 1'b0;
            frame_err_r    <= 1'b0;
        end else begin
            s1_valid_r <= in_valid;
            s1_last_r  <= in_valid && in_last;
            if (in_valid) begin
                prod_r <= PROD_W'(in_a) * PROD_W'(in_b);
            end
            push_r <= 1'b0;
            if (s1_valid_r) begin
                if (end_vec_s || s1_last_r) begin
                    push_r           <= 1'b1;
                    push_res_r.index <= vidx_r;
                    push_res_r.data  <= sum_s;
                    acc_r            <= '0;
                    ecnt_r           <= '0;
                    if (s1_last_r) begin
                        vidx_r <= '0;
                        if (!end_vec_s) begin
                            frame_err_r <= 1'b1;
                        end
                    end else if (vidx_r == IDX_W'(NUM_VECTORS - 1)) begin
                        vidx_r <= '0;
                    end else begin
                        vidx_r <= vidx_r + IDX_W'(1);
                    end
                end else begin
                    acc_r  <= sum_s;
                    ecnt_r <= ecnt_r + ECNT_W'(1);
                end
            end
            if (fifo_drop_s) begin
                overflow_err_r <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        state_r <= ACCUM;
                    end
                end
                ACCUM: begin
                    // A frame abutting the last one keeps the FSM in ACCUM.
                    if (s1_valid_r && s1_last_r && !in_valid) begin
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    dotp_result_fifo #(
        .T(res_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_r),
        .push_data (push_res_r),
        .pop       (result_ready),
        .head      (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .dropped   (fifo_drop_s)
    );

    assign result_data  = head_s.data;
    assign result_index = head_s.index;
    assign result_valid = !fifo_empty_s;
    assign busy         = (state_r != IDLE) || s1_valid_r;
    assign overflow_err = overflow_err_r;
    assign frame_err    = frame_err_r;

    logic unused_full_s;
    assign unused_full_s = fifo_full_s;

endmodule
